// File: rtl/mem_access.sv
// Memory stage: issues loads/stores over a valid/ready data bus, steers byte lanes
// and extends load data. Optional MEM_MISALIGN_TRAP_EN traps misaligned accesses.
module mem_access #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic [3:0]    op_type,
  input  logic [4:0]    op_spec,
  input  logic [4:0]    rd_ind,
  input  logic [DW-1:0] rd_dat,
  input  logic [31:0]   mem_addr,
  input  logic [DW-1:0] mem_dat,
  input  logic          mem_read_en,
  input  logic          mem_write_en,
  input  logic          flsh,
  output logic          stall_out,
  output logic          dbus_req_valid,
  input  logic          dbus_req_ready,
  output logic [AW-1:0] dbus_addr,
  output logic          dbus_we,
  output logic [3:0]    dbus_be,
  output logic [DW-1:0] dbus_wdata,
  input  logic          dbus_rsp_valid,
  input  logic [DW-1:0] dbus_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic          misalign_err,
`endif
  output logic          wb_valid,
  output logic [3:0]    op_type_out,
  output logic [4:0]    op_spec_out,
  output logic [4:0]    rd_ind_out,
  output logic [DW-1:0] rd_dat_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;
  state_t state_q, state_d;

  logic [AW-1:0] addr_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [DW-1:0] wdata_q;
  logic [4:0]    spec_q;
  logic [1:0]    off_q;
  logic [4:0]    rd_ind_q;
  logic [3:0]    op_type_q;
  logic          kill_q;
  logic          wb_valid_q;
  logic [DW-1:0] rd_dat_out_q;
  logic [3:0]    op_type_out_q;
  logic [4:0]    op_spec_out_q;
  logic [4:0]    rd_ind_out_q;

  logic [1:0]    off;
  logic [1:0]    off_eff;
  logic          is_half, is_word, misal;
  logic [3:0]    be_c;
  logic [DW-1:0] wdata_c;
  logic          accept, mem_acc, go, hs;
  logic [DW-1:0] lane_c, load_c;

  assign off     = mem_addr[1:0];
  assign is_half = (op_spec == 5'd1) || (op_spec == 5'd4) || (op_spec == 5'd6);
  assign is_word = (op_spec == 5'd2) || (op_spec == 5'd7);
  assign misal   = (is_half & off[0]) | (is_word & (off != 2'd0));
  // Misaligned halfwords fall back to their containing half, words to offset 0.
  assign off_eff = is_word ? 2'd0 : (is_half ? {off[1], 1'b0} : off);

  always_comb begin
    be_c = 4'b1111;
    if (mem_write_en) begin
      case (op_spec)
        5'd5:    be_c = 4'b0001 << off_eff;
        5'd6:    be_c = 4'b0011 << off_eff;
        default: be_c = 4'b1111;
      endcase
    end
  end
  assign wdata_c = mem_dat << {off_eff, 3'b000};

  assign accept  = (state_q == IDLE) & valid_in & ~flsh;
  assign mem_acc = accept & (mem_read_en | mem_write_en);
`ifdef MEM_MISALIGN_TRAP_EN
  logic trap;
  logic misalign_err_q;
  assign trap         = mem_acc & misal;
  assign go           = mem_acc & ~misal;
  assign misalign_err = misalign_err_q;
`else
  assign go = mem_acc;
`endif
  assign hs = dbus_req_valid & dbus_req_ready;

  assign lane_c = dbus_rdata >> {off_q, 3'b000};
  always_comb begin
    case (spec_q)
      5'd0:    load_c = {{24{lane_c[7]}}, lane_c[7:0]};
      5'd1:    load_c = {{16{lane_c[15]}}, lane_c[15:0]};
      5'd3:    load_c = {24'd0, lane_c[7:0]};
      5'd4:    load_c = {16'd0, lane_c[15:0]};
      default: load_c = lane_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (go) state_d = REQ;
      REQ: begin
        if (hs)        state_d = we_q ? IDLE : RSP;
        else if (flsh) state_d = IDLE;
      end
      RSP:  if (dbus_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the request combinationally so it drops in the cycle reset is seen.
  always_comb begin
    dbus_req_valid = (state_q == REQ) & ~rst;
    stall_out      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      we_q          <= 1'b0;
      be_q          <= '0;
      wdata_q       <= '0;
      spec_q        <= '0;
      off_q         <= '0;
      rd_ind_q      <= '0;
      op_type_q     <= '0;
      kill_q        <= 1'b0;
      wb_valid_q    <= 1'b0;
      rd_dat_out_q  <= '0;
      op_type_out_q <= '0;
      op_spec_out_q <= '0;
      rd_ind_out_q  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_err_q <= 1'b0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_err_q <= 1'b0;
      if (trap) begin
        wb_valid_q     <= 1'b1;
        misalign_err_q <= 1'b1;
        rd_dat_out_q   <= mem_addr;
        op_type_out_q  <= op_type;
        op_spec_out_q  <= op_spec;
        rd_ind_out_q   <= rd_ind;
      end
`endif
      if (accept & ~mem_read_en & ~mem_write_en) begin
        wb_valid_q    <= 1'b1;
        rd_dat_out_q  <= rd_dat;
        op_type_out_q <= op_type;
        op_spec_out_q <= op_spec;
        rd_ind_out_q  <= rd_ind;
      end
      if (go) begin
        addr_q    <= {mem_addr[AW-1:2], 2'b00};
        we_q      <= mem_write_en;
        be_q      <= be_c;
        wdata_q   <= wdata_c;
        spec_q    <= op_spec;
        off_q     <= off_eff;
        rd_ind_q  <= rd_ind;
        op_type_q <= op_type;
      end
      if (hs & we_q & ~flsh) begin
        wb_valid_q    <= 1'b1;
        rd_dat_out_q  <= '0;
        op_type_out_q <= op_type_q;
        op_spec_out_q <= spec_q;
        rd_ind_out_q  <= rd_ind_q;
      end
      // A flushed load still owes us a response; remember to swallow it.
      if (hs & ~we_q)                       kill_q <= flsh;
      else if ((state_q == RSP) & flsh)     kill_q <= 1'b1;
      if ((state_q == RSP) & dbus_rsp_valid & ~kill_q & ~flsh) begin
        wb_valid_q    <= 1'b1;
        rd_dat_out_q  <= load_c;
        op_type_out_q <= op_type_q;
        op_spec_out_q <= spec_q;
        rd_ind_out_q  <= rd_ind_q;
      end
    end
  end

  assign dbus_addr   = addr_q;
  assign dbus_we     = we_q;
  assign dbus_be     = be_q;
  assign dbus_wdata  = wdata_q;
  assign wb_valid    = wb_valid_q;
  assign rd_dat_out  = rd_dat_out_q;
  assign op_type_out = op_type_out_q;
  assign op_spec_out = op_spec_out_q;
  assign rd_ind_out  = rd_ind_out_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table of single accesses plus
// hand-written stall, flush, reset and misalignment sequences.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [3:0]  op_type;
  logic [4:0]  op_spec, rd_ind;
  logic [31:0] rd_dat, mem_addr, mem_dat;
  logic        mem_read_en, mem_write_en, flsh;
  logic        stall_out, dbus_req_valid, dbus_req_ready, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        dbus_rsp_valid, wb_valid;
  logic [3:0]  op_type_out;
  logic [4:0]  op_spec_out, rd_ind_out;
  logic [31:0] rd_dat_out;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .op_type(op_type), .op_spec(op_spec),
    .rd_ind(rd_ind), .rd_dat(rd_dat), .mem_addr(mem_addr), .mem_dat(mem_dat),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .flsh(flsh),
    .stall_out(stall_out), .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready),
    .dbus_addr(dbus_addr), .dbus_we(dbus_we), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_rsp_valid(dbus_rsp_valid), .dbus_rdata(dbus_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .wb_valid(wb_valid), .op_type_out(op_type_out), .op_spec_out(op_spec_out),
    .rd_ind_out(rd_ind_out), .rd_dat_out(rd_dat_out)
  );

  typedef struct {
    logic [4:0]  spec;
    logic [31:0] addr;
    logic [31:0] dat;
    logic        we;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] daddr;
    logic [31:0] rd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    valid_in = 0; op_type = 0; op_spec = 0; rd_ind = 0; rd_dat = 0;
    mem_addr = 0; mem_dat = 0; mem_read_en = 0; mem_write_en = 0; flsh = 0;
    dbus_req_ready = 0; dbus_rsp_valid = 0; dbus_rdata = 0;
  endtask

  task automatic present(input logic [4:0] spec, input logic [31:0] addr,
                         input logic [31:0] dat, input logic we);
    valid_in = 1; op_type = 4'd1; op_spec = spec; rd_ind = 5'd7;
    mem_addr = addr; mem_dat = dat; mem_write_en = we; mem_read_en = ~we;
    tick();
    valid_in = 0; mem_write_en = 0; mem_read_en = 0;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    string s;
    s = $sformatf("vec%0d", i);
    present(v.spec, v.addr, v.dat, v.we);
    @(negedge clk);
    chk({s, ".req_valid"}, {31'd0, dbus_req_valid}, 32'd1);
    chk({s, ".addr"}, dbus_addr, v.daddr);
    chk({s, ".be"}, {28'd0, dbus_be}, {28'd0, v.be});
    chk({s, ".we"}, {31'd0, dbus_we}, {31'd0, v.we});
    if (v.we) chk({s, ".wdata"}, dbus_wdata, v.wdata);
    dbus_req_ready = 1;
    tick();
    dbus_req_ready = 0;
    if (!v.we) begin
      @(negedge clk);
      chk({s, ".rsp_wait_wb"}, {31'd0, wb_valid}, 32'd0);
      dbus_rsp_valid = 1; dbus_rdata = v.rdata;
      tick();
      dbus_rsp_valid = 0;
    end
    @(negedge clk);
    chk({s, ".wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({s, ".rd_dat_out"}, rd_dat_out, v.rd);
    chk({s, ".rd_ind_out"}, {27'd0, rd_ind_out}, 32'd7);
    chk({s, ".stall"}, {31'd0, stall_out}, 32'd0);
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick(); tick();
    @(negedge clk);
    chk("reset.req_valid", {31'd0, dbus_req_valid}, 32'd0);
    chk("reset.stall", {31'd0, stall_out}, 32'd0);
    chk("reset.wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset.rd_dat_out", rd_dat_out, 32'd0);
    chk("reset.be", {28'd0, dbus_be}, 32'd0);
    rst = 0;
    tick();

    // spec, addr, dat, we, rdata, be, wdata, daddr, rd
    vq.push_back('{5'd7, 32'h200, 32'hDEADBEEF, 1'b1, 32'h0, 4'b1111, 32'hDEADBEEF, 32'h200, 32'h0});
    vq.push_back('{5'd6, 32'h202, 32'h00001234, 1'b1, 32'h0, 4'b1100, 32'h12340000, 32'h200, 32'h0});
    vq.push_back('{5'd5, 32'h101, 32'h000000AB, 1'b1, 32'h0, 4'b0010, 32'h0000AB00, 32'h100, 32'h0});
    vq.push_back('{5'd0, 32'h102, 32'h0, 1'b0, 32'h00F30000, 4'b1111, 32'h0, 32'h100, 32'hFFFFFFF3});
    vq.push_back('{5'd3, 32'h102, 32'h0, 1'b0, 32'h00F30000, 4'b1111, 32'h0, 32'h100, 32'h000000F3});
    vq.push_back('{5'd4, 32'h102, 32'h0, 1'b0, 32'h00F30000, 4'b1111, 32'h0, 32'h100, 32'h000000F3});
    vq.push_back('{5'd1, 32'h100, 32'h0, 1'b0, 32'h12348001, 4'b1111, 32'h0, 32'h100, 32'hFFFF8001});
    vq.push_back('{5'd2, 32'h104, 32'h0, 1'b0, 32'hCAFEF00D, 4'b1111, 32'h0, 32'h104, 32'hCAFEF00D});
    vq.push_back('{5'd0, 32'h103, 32'h0, 1'b0, 32'h7F000000, 4'b1111, 32'h0, 32'h100, 32'h0000007F});
`ifndef MEM_MISALIGN_TRAP_EN
    vq.push_back('{5'd2, 32'h101, 32'h0, 1'b0, 32'h11223344, 4'b1111, 32'h0, 32'h100, 32'h11223344});
    vq.push_back('{5'd6, 32'h103, 32'h000055AA, 1'b1, 32'h0, 4'b1100, 32'h55AA0000, 32'h100, 32'h0});
`endif
    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

    // Non-memory instruction, 1-cycle latency
    valid_in = 1; op_type = 4'd0; op_spec = 5'd0; rd_dat = 32'h1234; rd_ind = 5'd5;
    @(negedge clk);
    chk("alu.stall_accept", {31'd0, stall_out}, 32'd0);
    tick();
    valid_in = 0;
    @(negedge clk);
    chk("alu.wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("alu.rd_dat_out", rd_dat_out, 32'h1234);
    chk("alu.rd_ind_out", {27'd0, rd_ind_out}, 32'd5);
    chk("alu.stall", {31'd0, stall_out}, 32'd0);
    tick();
    @(negedge clk);
    chk("alu.wb_pulse", {31'd0, wb_valid}, 32'd0);

    // sb at 0x103 with ready held low for 3 cycles
    tick();
    present(5'd5, 32'h103, 32'hAB, 1'b1);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) dbus_req_ready = 1;
      @(negedge clk);
      chk($sformatf("sb.stall%0d", c), {31'd0, stall_out}, 32'd1);
      chk($sformatf("sb.req%0d", c), {31'd0, dbus_req_valid}, 32'd1);
      chk($sformatf("sb.be%0d", c), {28'd0, dbus_be}, 32'h8);
      chk($sformatf("sb.wdata%0d", c), dbus_wdata, 32'hAB000000);
      chk($sformatf("sb.addr%0d", c), dbus_addr, 32'h100);
      chk($sformatf("sb.nowb%0d", c), {31'd0, wb_valid}, 32'd0);
      tick();
    end
    dbus_req_ready = 0;
    @(negedge clk);
    chk("sb.wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("sb.req_drop", {31'd0, dbus_req_valid}, 32'd0);
    tick();

    // lw flushed while waiting in RSP
    present(5'd2, 32'h100, 32'h0, 1'b0);
    dbus_req_ready = 1;
    tick();
    dbus_req_ready = 0; flsh = 1;
    tick();
    flsh = 0; dbus_rsp_valid = 1; dbus_rdata = 32'h55555555;
    @(negedge clk);
    chk("flrsp.stall_rsp", {31'd0, stall_out}, 32'd1);
    tick();
    dbus_rsp_valid = 0;
    @(negedge clk);
    chk("flrsp.idle", {31'd0, stall_out}, 32'd0);
    chk("flrsp.nowb", {31'd0, wb_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("flrsp.nowb2", {31'd0, wb_valid}, 32'd0);

    // Flush in REQ before handshake
    tick();
    present(5'd7, 32'h300, 32'h1, 1'b1);
    flsh = 1;
    tick();
    flsh = 0;
    @(negedge clk);
    chk("flreq.req_drop", {31'd0, dbus_req_valid}, 32'd0);
    chk("flreq.stall", {31'd0, stall_out}, 32'd0);
    chk("flreq.nowb", {31'd0, wb_valid}, 32'd0);

    // Reset while a request is outstanding
    tick();
    present(5'd7, 32'h400, 32'h2, 1'b1);
    @(negedge clk);
    chk("rstreq.req_before", {31'd0, dbus_req_valid}, 32'd1);
    rst = 1;
    #1;
    chk("rstreq.req_same", {31'd0, dbus_req_valid}, 32'd0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("rstreq.req_after", {31'd0, dbus_req_valid}, 32'd0);
    chk("rstreq.stall", {31'd0, stall_out}, 32'd0);
    chk("rstreq.nowb", {31'd0, wb_valid}, 32'd0);
    dbus_req_ready = 1;
    tick();
    dbus_req_ready = 0;
    @(negedge clk);
    chk("rstreq.nowb2", {31'd0, wb_valid}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
    tick();
    present(5'd2, 32'h101, 32'h0, 1'b0);
    @(negedge clk);
    chk("trap.req", {31'd0, dbus_req_valid}, 32'd0);
    chk("trap.stall", {31'd0, stall_out}, 32'd0);
    chk("trap.wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("trap.err", {31'd0, misalign_err}, 32'd1);
    chk("trap.rd_dat_out", rd_dat_out, 32'h101);
    tick();
    @(negedge clk);
    chk("trap.err_pulse", {31'd0, misalign_err}, 32'd0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
